// File: rtl/instr_loader_pkg.sv
// Shared types and defaults for the boot-time instruction loader.
// LOADER_CHECKSUM_EN adds the CSUM state and the checksum fold helper.
package risc_loader_pkg;

    localparam int DEF_MEM_WORDS = 256;
    localparam int DEF_ADDR_W    = 8;

    typedef enum logic [2:0] {
        ST_HDR_HI = 3'd0,
        ST_HDR_LO = 3'd1,
        ST_LOAD   = 3'd2,
        ST_RUN    = 3'd3,
`ifdef LOADER_CHECKSUM_EN
        ST_ERR    = 3'd4,
        ST_CSUM   = 3'd5
`else
        ST_ERR    = 3'd4
`endif
    } state_e;

`ifdef LOADER_CHECKSUM_EN
    // Running XOR over every payload byte of the stream.
    function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] data);
        return acc ^ data;
    endfunction
`endif

endpackage

// File: rtl/instr_loader_if.sv
// Byte-stream input and instruction-memory write bus of the loader.
// master = loader side, slave = stream source / memory / processor side.
interface instr_loader_if
    import risc_loader_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_wdata;
    logic              cpu_rst;
    logic              done;
    logic              err;

    modport master (
        input  in_valid, in_data,
        output in_ready, im_we, im_addr, im_wdata, cpu_rst, done, err
    );

    modport slave (
        output in_valid, in_data,
        input  in_ready, im_we, im_addr, im_wdata, cpu_rst, done, err
    );
endinterface

// File: rtl/instr_loader_byte_packer.sv
// Assembles big-endian 32-bit words from accepted bytes; word/word_valid
// are registered so word_valid is high in the cycle after the fourth byte.
module byte_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [1:0]  byte_cnt,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [23:0] shift_q, shift_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] word_q, word_d;
    logic        word_valid_q, word_valid_d;

    // Next-state: shift in bytes, emit a word on every fourth one.
    always_comb begin
        shift_d      = shift_q;
        cnt_d        = cnt_q;
        word_d       = word_q;
        word_valid_d = 1'b0;
        if (byte_valid) begin
            shift_d = {shift_q[15:0], byte_data};
            cnt_d   = cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
                word_d       = {shift_q, byte_data};
                word_valid_d = 1'b1;
            end else begin
                word_d       = word_q;
                word_valid_d = 1'b0;
            end
        end else begin
            shift_d = shift_q;
            cnt_d   = cnt_q;
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q      <= 24'd0;
            cnt_q        <= 2'd0;
            word_q       <= 32'd0;
            word_valid_q <= 1'b0;
        end else begin
            shift_q      <= shift_d;
            cnt_q        <= cnt_d;
            word_q       <= word_d;
            word_valid_q <= word_valid_d;
        end
    end

    assign byte_cnt   = cnt_q;
    assign word       = word_q;
    assign word_valid = word_valid_q;

endmodule

// File: rtl/instr_loader.sv
// Loads a length-prefixed big-endian program stream into instruction memory
// and releases the processor. LOADER_CHECKSUM_EN adds a trailing XOR byte check.
module instr_loader
    import risc_loader_pkg::*;
#(
    parameter int MEM_WORDS = DEF_MEM_WORDS,
    parameter int ADDR_W    = DEF_ADDR_W
) (
    input  logic           clk,
    input  logic           rst,
    instr_loader_if.master bus
);

    localparam logic [16:0] MAX_N = 17'(MEM_WORDS);

    state_e            state_q, state_d;
    logic [7:0]        n_hi_q, n_hi_d;
    logic [15:0]       n_q, n_d;
    logic [15:0]       word_idx_q, word_idx_d;
    logic [ADDR_W-1:0] im_addr_q, im_addr_d;
    logic              in_ready_q, in_ready_d;
    logic              cpu_rst_q, cpu_rst_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;
`endif

    logic        accept_s;
    logic        pk_valid_s;
    logic        fourth_s;
    logic        last_word_s;
    logic [15:0] n_s;
    logic [1:0]  pk_cnt_s;
    logic [31:0] pk_word_s;
    logic        pk_word_valid_s;

    assign accept_s    = bus.in_valid && in_ready_q;
    assign pk_valid_s  = accept_s && (state_q == ST_LOAD);
    assign fourth_s    = pk_valid_s && (pk_cnt_s == 2'd3);
    assign last_word_s = (word_idx_q == (n_q - 16'd1));
    assign n_s         = {n_hi_q, bus.in_data};

    byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .byte_valid (pk_valid_s),
        .byte_data  (bus.in_data),
        .byte_cnt   (pk_cnt_s),
        .word       (pk_word_s),
        .word_valid (pk_word_valid_s)
    );

    // FSM next-state and output decode.
    always_comb begin
        state_d    = state_q;
        n_hi_d     = n_hi_q;
        n_d        = n_q;
        word_idx_d = word_idx_q;
        im_addr_d  = im_addr_q;
`ifdef LOADER_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        case (state_q)
            ST_HDR_HI: begin
                if (accept_s) begin
                    n_hi_d  = bus.in_data;
                    state_d = ST_HDR_LO;
                end else begin
                    state_d = ST_HDR_HI;
                end
            end
            ST_HDR_LO: begin
                if (accept_s) begin
                    n_d        = n_s;
                    word_idx_d = 16'd0;
`ifdef LOADER_CHECKSUM_EN
                    csum_d     = 8'd0;
`endif
                    if ((n_s == 16'd0) || ({1'b0, n_s} > MAX_N)) begin
                        state_d = ST_ERR;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else begin
                    state_d = ST_HDR_LO;
                end
            end
            ST_LOAD: begin
`ifdef LOADER_CHECKSUM_EN
                if (pk_valid_s) begin
                    csum_d = csum_step(csum_q, bus.in_data);
                end else begin
                    csum_d = csum_q;
                end
`endif
                if (fourth_s) begin
                    im_addr_d  = word_idx_q[ADDR_W-1:0];
                    word_idx_d = word_idx_q + 16'd1;
                    if (last_word_s) begin
`ifdef LOADER_CHECKSUM_EN
                        state_d = ST_CSUM;
`else
                        state_d = ST_RUN;
`endif
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else begin
                    state_d = ST_LOAD;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CSUM: begin
                if (accept_s) begin
                    if (bus.in_data == csum_q) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_ERR;
                    end
                end else begin
                    state_d = ST_CSUM;
                end
            end
`endif
            ST_RUN:  state_d = ST_RUN;
            ST_ERR:  state_d = ST_ERR;
            default: state_d = ST_ERR;
        endcase

`ifdef LOADER_CHECKSUM_EN
        in_ready_d = (state_d == ST_HDR_HI) || (state_d == ST_HDR_LO) ||
                     (state_d == ST_LOAD)   || (state_d == ST_CSUM);
`else
        in_ready_d = (state_d == ST_HDR_HI) || (state_d == ST_HDR_LO) ||
                     (state_d == ST_LOAD);
`endif
        // Status lags the state by one cycle so done follows the last write pulse.
        done_d    = (state_q == ST_RUN);
        err_d     = (state_q == ST_ERR);
        cpu_rst_d = (state_q != ST_RUN);
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_HDR_HI;
            n_hi_q     <= 8'd0;
            n_q        <= 16'd0;
            word_idx_q <= 16'd0;
            im_addr_q  <= '0;
            in_ready_q <= 1'b1;
            cpu_rst_q  <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= 8'd0;
`endif
        end else begin
            state_q    <= state_d;
            n_hi_q     <= n_hi_d;
            n_q        <= n_d;
            word_idx_q <= word_idx_d;
            im_addr_q  <= im_addr_d;
            in_ready_q <= in_ready_d;
            cpu_rst_q  <= cpu_rst_d;
            done_q     <= done_d;
            err_q      <= err_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    assign bus.in_ready = in_ready_q;
    assign bus.im_we    = pk_word_valid_s;
    assign bus.im_addr  = im_addr_q;
    assign bus.im_wdata = pk_word_s;
    assign bus.cpu_rst  = cpu_rst_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;

endmodule

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 The block SHALL have parameter MEM_WORDS, default 256, giving the instruction memory depth in 32-bit words.
REQ-002 The block SHALL have parameter ADDR_W, default 8, giving the word-address width, with 2**ADDR_W >= MEM_WORDS.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  a byte is offered on in_data.
REQ-006 in_data  input  8  program stream byte.
REQ-007 in_ready  output  1  block accepts a byte this cycle; transfer when in_valid && in_ready.
REQ-008 im_we  output  1  instruction-memory write strobe, one-cycle pulse.
REQ-009 im_addr  output  ADDR_W  instruction-memory word address.
REQ-010 im_wdata  output  32  instruction word to write.
REQ-011 cpu_rst  output  1  reset to the processor; high while loading or on error.
REQ-012 done  output  1  load complete; processor running.
REQ-013 err  output  1  load failed; sticky until rst.

Function
REQ-014 The stream SHALL be: 2-byte big-endian word count N, then 4*N bytes, each word big-endian (first byte = bits 31:24).
REQ-015 The block SHALL implement an FSM with states HDR_HI -> HDR_LO -> LOAD -> RUN, plus ERR.
REQ-016 in_ready SHALL be 1 in HDR_HI, HDR_LO and LOAD, and 0 in RUN and ERR.
REQ-017 On accepting the second header byte, the block SHALL go to ERR if N == 0 or N > MEM_WORDS, and otherwise go to LOAD with word index 0.
REQ-018 In LOAD, on the fourth accepted byte of a word, im_we SHALL be 1 in the following cycle, with im_addr = word index and im_wdata = the assembled word.
REQ-019 The word index SHALL then increment; byte acceptance continues with no bubble during the write cycle.
REQ-020 im_we SHALL be 0 in every other cycle; im_addr and im_wdata hold their last values when im_we is 0.
REQ-021 After the write of word N-1, the block SHALL enter RUN; cpu_rst falls and done rises in the cycle after that im_we pulse.
REQ-022 Idle cycles (in_valid = 0) SHALL stall the FSM and byte counter without loss of partial data.
REQ-023 Bytes offered in RUN or ERR SHALL be ignored, and the block SHALL remain in that state.
REQ-024 In ERR, err = 1, cpu_rst = 1 and done = 0, and no further im_we pulses occur.

Reset
REQ-025 While rst = 1 at a posedge, the state SHALL become HDR_HI with byte counter 0, word index 0, im_we 0, im_addr 0, im_wdata 0, cpu_rst 1, done 0, err 0.
REQ-026 rst asserted mid-load SHALL abandon the partial word and all progress; the next stream restarts at the header and rewrites from address 0.
REQ-027 cpu_rst SHALL remain 1 from reset until RUN is reached.

Configuration
REQ-028 With macro LOADER_CHECKSUM_EN defined, a CSUM state SHALL follow the last word: one extra byte is accepted and compared with the XOR of all 4*N payload bytes.
REQ-029 With LOADER_CHECKSUM_EN defined, a checksum match SHALL lead to RUN, and a mismatch SHALL lead to ERR.
REQ-030 With LOADER_CHECKSUM_EN defined, RUN SHALL be entered on the cycle after the checksum byte, never before the last im_we.
REQ-031 Without LOADER_CHECKSUM_EN, the block SHALL have no CSUM state or XOR register, and SHALL behave per REQ-021.

Structure
REQ-032 Package risc_loader_pkg SHALL hold the FSM state enum and default constants for MEM_WORDS and ADDR_W.
REQ-033 Sub-module byte_packer SHALL contain the byte shift register and the 2-bit byte counter, outputting word and word_valid pulse; the FSM stays in instr_loader.

Verification
REQ-034 Stream 00 01 12 34 56 78 -> one im_we with im_addr 0, im_wdata 0x12345678; cpu_rst falls and done = 1 the next cycle.
REQ-035 Header 00 00 -> err = 1, in_ready = 0, cpu_rst stays 1; header 01 01 with MEM_WORDS = 256 -> err = 1.
REQ-036 N = 256 back-to-back bytes -> 256 im_we pulses at addresses 0..255 with no in_ready drop; the last address wraps to nothing, and done follows.
REQ-037 N = 2 with in_valid deasserted for 3 cycles mid-word -> words intact at addresses 0 and 1.
REQ-038 rst after 6 payload bytes, then a fresh stream of N = 1 -> exactly one write to address 0, done = 1.
REQ-039 With LOADER_CHECKSUM_EN defined, stream 00 01 01 02 03 04 04 -> done; the same stream with final byte 05 -> err = 1.
